i2c_target_regbank: RTL and testbench

Oversampling I2C target (responder) that answers the camera-configuration write protocol (7-bit device address, 16-bit register address, 8-bit data) and also supports random/sequential reads via repeated START. It sits between an external I2C bus and a simple register-bank port. It is used to emulate a camera sensor for board-to-board links and for closed-loop checking of the SCCB/I2C configuration master.

---
 rtl/i2c_pkg.sv | 11 +
 rtl/i2c_pin_filter.sv | 31 +++
 rtl/i2c_target_regbank.sv | 125 ++++++++++++
 tb/tb_i2c_target_regbank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C register-bank target.
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, DEV, ADDR_H, ADDR_L, WDATA, RDATA, MACK} i2c_state_e;
  typedef struct packed {
    i2c_state_e st;
    logic       ack;
  } i2c_phase_t;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic [6:0] I2C_DEV_ADDR = 7'h3C;
endpackage

// File: rtl/i2c_pin_filter.sv
// i2c_pin_filter: 2-flop synchronizer plus LEN-sample stability filter with edge pulses.
module i2c_pin_filter #(
  parameter int LEN = 3
) (
  input  logic clock_sys,
  input  logic sys_rstn,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = (sync[1] != level) && (cnt == CW'(LEN - 1));
  always_ff @(posedge clock_sys or negedge sys_rstn)
    if (!sys_rstn) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      cnt <= (sync[1] != level && !flip) ? cnt + 1'b1 : '0;
      level <= flip ? sync[1] : level;
      rise <= flip & sync[1];
      fall <= flip & ~sync[1];
    end
endmodule

// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank: oversampling I2C target with 16-bit register addressing,
// write bursts and sequential reads through repeated START.
module i2c_target_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR,
  parameter int FILT_LEN = 3
) (
  input  logic        clock_sys,
  input  logic        sys_rstn,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] reg_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        busy
);
  typedef struct packed {
    i2c_phase_t  ph;
    logic [3:0]  bcnt;
    logic [7:0]  sh;
    logic [7:0]  tx;
    logic        sda_oe;
    logic [1:0]  rdly;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        wr;
    logic        rd;
    logic        busy;
  } regs_t;
  regs_t r, n;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, rx_st;
  logic [7:0] rx_byte;
  i2c_pin_filter #(.LEN(FILT_LEN)) u_scl (
    .clock_sys(clock_sys), .sys_rstn(sys_rstn), .pin(i2c_sclk),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_pin_filter #(.LEN(FILT_LEN)) u_sda (
    .clock_sys(clock_sys), .sys_rstn(sys_rstn), .pin(i2c_sdat),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );
  assign start = sda_fall & scl_lvl;
  assign stop = sda_rise & scl_lvl;
  assign rx_st = r.ph.st inside {DEV, ADDR_H, ADDR_L, WDATA};
  assign rx_byte = {r.sh[6:0], sda_lvl};
  assign i2c_sdat = r.sda_oe ? I2C_ACK : 1'bz;
  assign reg_addr = r.addr;
  assign wr_data = r.wdat;
  assign wr_en = r.wr;
  assign rd_en = r.rd;
  assign busy = r.busy;
  always_ff @(posedge clock_sys or negedge sys_rstn)
    if (!sys_rstn) r <= '0;
    else r <= n;
  always_comb begin
    n = r;
    n.wr = 1'b0;
    n.rd = 1'b0;
    n.rdly = (r.rdly != 2'd0) ? r.rdly - 2'd1 : 2'd0;
    if (r.wr) n.addr = r.addr + 16'd1;
    // read pipeline: capture rd_data two cycles after rd_en, drive MSB one cycle later
    if (r.rdly == 2'd2) n.tx = rd_data;
    if (r.rdly == 2'd1) begin
      n.sda_oe = ~r.tx[7];
      n.tx = {r.tx[6:0], 1'b0};
    end
    if (start) begin
      n.ph = '{DEV, 1'b0};
      n.bcnt = 4'd0;
      n.sda_oe = 1'b0;
      n.rdly = 2'd0;
    end else if (stop) begin
      n.ph = '{IDLE, 1'b0};
      n.sda_oe = 1'b0;
      n.busy = 1'b0;
      n.rdly = 2'd0;
    end else if (scl_rise && !r.ph.ack) begin
      if (rx_st) begin
        n.sh = rx_byte;
        n.bcnt = r.bcnt + 4'd1;
        if (r.bcnt == 4'd7 && r.ph.st == ADDR_H) n.addr[15:8] = rx_byte;
        if (r.bcnt == 4'd7 && r.ph.st == ADDR_L) n.addr[7:0] = rx_byte;
        if (r.bcnt == 4'd7 && r.ph.st == WDATA) begin
          n.wr = 1'b1;
          n.wdat = rx_byte;
        end
      end else if (r.ph.st == RDATA) n.bcnt = r.bcnt + 4'd1;
      else if (r.ph.st == MACK && sda_lvl == I2C_NACK) begin
        n.ph = '{IDLE, 1'b0};
        n.busy = 1'b0;
      end else if (r.ph.st == MACK) begin
        n.ph.ack = 1'b1;
        n.addr = r.addr + 16'd1;
      end
    end else if (scl_fall && r.ph.ack) begin
      n.ph.ack = 1'b0;
      n.bcnt = 4'd0;
      n.sda_oe = 1'b0;
      n.rd = (r.ph.st == MACK) || (r.ph.st == DEV && r.sh[0]);
      n.rdly = n.rd ? 2'd3 : 2'd0;
      n.ph.st = n.rd ? RDATA : (r.ph.st == DEV) ? ADDR_H : (r.ph.st == ADDR_H) ? ADDR_L : WDATA;
    end else if (scl_fall && rx_st && r.bcnt == 4'd8) begin
      if (r.ph.st == DEV && r.sh[7:1] != DEV_ADDR) begin
        n.ph = '{IDLE, 1'b0};
        n.busy = 1'b0;
      end else begin
        n.ph.ack = 1'b1;
        n.sda_oe = 1'b1;
        n.busy = 1'b1;
      end
    end else if (scl_fall && r.ph.st == RDATA) begin
      if (r.bcnt == 4'd8) begin
        n.ph.st = MACK;
        n.bcnt = 4'd0;
        n.sda_oe = 1'b0;
      end else if (r.bcnt != 4'd0) begin
        n.sda_oe = ~r.tx[7];
        n.tx = {r.tx[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regbank.sv
// tb_i2c_target_regbank: I2C master model, register-bank model and scoreboard for the target.
module tb_i2c_target_regbank;
  logic clock_sys = 1'b0;
  logic sys_rstn = 1'b0;
  logic i2c_sclk = 1'b1;
  logic m_low = 1'b0;
  wire i2c_sdat;
  logic [15:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic wr_en, rd_en, busy;
  int npass = 0;
  int ntot = 0;
  logic [7:0] bank [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [15:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [15:0] rd_a [$];
  typedef struct {
    logic [7:0]      dev;
    logic [15:0]     addr;
    int              n;
    logic [2:0][7:0] d;
    bit              glitch;
    logic            dev_ack;
    logic [15:0]     addr_end;
  } vec_t;
  vec_t vecs [6];

  assign i2c_sdat = m_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);
  always #5 clock_sys = ~clock_sys;

  i2c_target_regbank dut (
    .clock_sys(clock_sys), .sys_rstn(sys_rstn), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .rd_data(rd_data), .busy(busy)
  );

  // register bank behind the target: one-cycle read latency, writes logged on strobes
  always @(posedge clock_sys) rd_data <= bank[reg_addr];
  always @(negedge clock_sys) begin
    if (wr_en) begin
      wr_a.push_back(reg_addr);
      wr_d.push_back(wr_data);
      bank[reg_addr] = wr_data;
    end
    if (rd_en) rd_a.push_back(reg_addr);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wt(input int c);
    repeat (c) @(negedge clock_sys);
  endtask

  task automatic bit_io(input logic b, output logic rb, input bit gl);
    m_low = ~b;
    wt(16);
    i2c_sclk = 1'b1;
    wt(16);
    rb = i2c_sdat;
    wt(16);
    i2c_sclk = 1'b0;
    if (gl) begin
      wt(8);
      i2c_sclk = 1'b1;
      wt(2);
      i2c_sclk = 1'b0;
      wt(6);
    end else wt(16);
  endtask

  task automatic m_start;
    m_low = 1'b0;
    wt(16);
    i2c_sclk = 1'b1;
    wt(16);
    m_low = 1'b1;
    wt(16);
    i2c_sclk = 1'b0;
    wt(16);
  endtask

  task automatic m_stop;
    m_low = 1'b1;
    wt(16);
    i2c_sclk = 1'b1;
    wt(16);
    m_low = 1'b0;
    wt(16);
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack, input bit gl);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_io(b[i], rb, gl && i == 3);
    bit_io(1'b1, ack, 1'b0);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, rb, 1'b0);
      b[i] = rb;
    end
    bit_io(nack, rb, 1'b0);
  endtask

  task automatic run_write(input logic [7:0] dev, input logic [15:0] a, input int n,
                           input logic [2:0][7:0] d, input bit gl, input logic exp_dev_ack,
                           input logic [15:0] exp_end, input string tag);
    logic ack;
    logic [15:0] ai;
    int exp_n;
    exp_n = (exp_dev_ack == 1'b0) ? n : 0;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    m_start;
    m_wbyte(dev, ack, 1'b0);
    chk({tag, " dev_ack"}, ack, exp_dev_ack);
    if (exp_dev_ack == 1'b0) begin
      chk({tag, " busy_on"}, busy, 1);
      m_wbyte(a[15:8], ack, 1'b0);
      chk({tag, " addr_h_ack"}, ack, 0);
      m_wbyte(a[7:0], ack, 1'b0);
      chk({tag, " addr_l_ack"}, ack, 0);
      for (int i = 0; i < n; i++) begin
        m_wbyte(d[i], ack, gl && i == 0);
        chk({tag, " data_ack"}, ack, 0);
        ai = a + 16'(i);
        ref_mem[ai] = d[i];
      end
    end
    m_stop;
    chk({tag, " busy_off"}, busy, 0);
    chk({tag, " sda_released"}, i2c_sdat, 1);
    chk({tag, " wr_count"}, wr_a.size(), exp_n);
    for (int i = 0; i < wr_a.size() && i < exp_n; i++) begin
      ai = a + 16'(i);
      chk({tag, " wr_addr"}, wr_a[i], ai);
      chk({tag, " wr_data"}, wr_d[i], d[i]);
    end
    chk({tag, " rd_count"}, rd_a.size(), 0);
    chk({tag, " reg_addr_end"}, reg_addr, exp_end);
  endtask

  task automatic run_read(input logic [15:0] a, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    logic [15:0] ai;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    m_start;
    m_wbyte(8'h78, ack, 1'b0);
    m_wbyte(a[15:8], ack, 1'b0);
    m_wbyte(a[7:0], ack, 1'b0);
    m_start;
    m_wbyte(8'h79, ack, 1'b0);
    chk({tag, " dev_r_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      m_rbyte(i == n - 1, b);
      ai = a + 16'(i);
      chk({tag, " rd_byte"}, b, ref_mem[ai]);
    end
    chk({tag, " busy_after_nack"}, busy, 0);
    chk({tag, " sda_after_nack"}, i2c_sdat, 1);
    m_stop;
    chk({tag, " rd_count"}, rd_a.size(), n);
    for (int i = 0; i < rd_a.size() && i < n; i++) begin
      ai = a + 16'(i);
      chk({tag, " rd_addr"}, rd_a[i], ai);
    end
    chk({tag, " wr_count"}, wr_a.size(), 0);
  endtask

  initial begin
    logic [7:0] dv;
    logic rb;
    logic [15:0] ra;
    logic [15:0] hold;
    int rn;
    logic [2:0][7:0] rd3;
    for (int i = 0; i < 65536; i++) begin
      bank[i] = i[7:0] ^ i[15:8] ^ 8'hA5;
      ref_mem[i] = i[7:0] ^ i[15:8] ^ 8'hA5;
    end
    vecs[0] = '{8'h78, 16'h3008, 1, 24'h000082, 1'b0, 1'b0, 16'h3009};
    vecs[1] = '{8'h78, 16'h3017, 2, 24'h0000FF, 1'b0, 1'b0, 16'h3019};
    vecs[2] = '{8'h42, 16'h0000, 1, 24'h000011, 1'b0, 1'b1, 16'h3019};
    vecs[3] = '{8'h78, 16'h1234, 1, 24'h0000A5, 1'b0, 1'b0, 16'h1235};
    vecs[4] = '{8'h78, 16'hFFFF, 2, 24'h002211, 1'b0, 1'b0, 16'h0001};
    vecs[5] = '{8'h78, 16'h0040, 1, 24'h00005A, 1'b1, 1'b0, 16'h0041};
    wt(4);
    chk("reset sda", i2c_sdat, 1);
    chk("reset busy", busy, 0);
    sys_rstn = 1'b1;
    wt(12);
    chk("reset reg_addr", reg_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset strobes", {wr_en, rd_en}, 0);
    for (int v = 0; v < 6; v++)
      run_write(vecs[v].dev, vecs[v].addr, vecs[v].n, vecs[v].d, vecs[v].glitch,
                vecs[v].dev_ack, vecs[v].addr_end, $sformatf("vec%0d", v));
    bank[16'h300A] = 8'h56;
    ref_mem[16'h300A] = 8'h56;
    run_read(16'h300A, 1, "rd300a");
    // START immediately followed by STOP, no clock pulse
    wr_a.delete();
    rd_a.delete();
    hold = reg_addr;
    m_low = 1'b1;
    wt(16);
    m_low = 1'b0;
    wt(16);
    chk("start_stop busy", busy, 0);
    chk("start_stop strobes", wr_a.size() + rd_a.size(), 0);
    chk("start_stop reg_addr", reg_addr, hold);
    for (int k = 0; k < 3; k++) begin
      ra = (k == 0) ? 16'hFFFF : 16'($urandom);
      rn = $urandom_range(1, 2);
      rd3 = 24'($urandom);
      run_write(8'h78, ra, rn, rd3, 1'b0, 1'b0, ra + 16'(rn), $sformatf("rnd_wr%0d", k));
      run_read(ra, $urandom_range(1, 2), $sformatf("rnd_rd%0d", k));
    end
    // reset while the target holds the ACK low
    dv = 8'h78;
    m_start;
    for (int i = 7; i >= 0; i--) bit_io(dv[i], rb, 1'b0);
    m_low = 1'b0;
    wt(1);
    chk("rst_mid ack_driven", i2c_sdat, 0);
    sys_rstn = 1'b0;
    #1;
    chk("rst_mid sda_released", i2c_sdat, 1);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid reg_addr", reg_addr, 0);
    wt(2);
    sys_rstn = 1'b1;
    wt(16);
    m_stop;
    run_write(8'h78, 16'h0ABC, 1, 24'h00003C, 1'b0, 1'b0, 16'h0ABD, "post_rst");
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
